// File: rtl/decoder_pkg.sv
// Shared decoder types plus the CSR address constants used by csr_file.
package decoder_pkg;

  typedef logic [31:0] word;
  typedef logic [4:0]  r;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_t;

  localparam int unsigned CSR_ADDR_W    = 12;
  localparam logic [1:0]  CSR_RO_PREFIX = 2'b11;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;

endpackage

// File: rtl/csr_file_if.sv
// CSR access request from the decoder and the registered write-back to rd.
interface csr_file_if;
  import decoder_pkg::*;

  logic                  csr_enable;
  logic [CSR_ADDR_W-1:0] csr_addr;
  csr_t                  op;
  r                      rs1;
  r                      rd;
  word                   in;
  logic                  wb_en;
  r                      wb_rd;
  word                   wb_data;
  logic                  illegal;

  modport master (
    output csr_enable, csr_addr, op, rs1, rd, in,
    input  wb_en, wb_rd, wb_data, illegal
  );

  modport slave (
    input  csr_enable, csr_addr, op, rs1, rd, in,
    output wb_en, wb_rd, wb_data, illegal
  );

endinterface

// File: rtl/csr_file_csr.sv
// Single CSR slot: applies the CSR read-modify-write op when enabled.
module csr
  import decoder_pkg::*;
#(
  parameter word ResetValue = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  csr_t i_op,
  input  r     i_rs1,
  input  word  i_in,
  output word  o_data
);

  word r_data;
  word w_next;
  word w_zimm;

  assign w_zimm = {27'b0, i_rs1};

  always_comb begin
    w_next = r_data;
    case (i_op)
      CSRRW:   w_next = i_in;
      CSRRS:   w_next = r_data | i_in;
      CSRRC:   w_next = r_data & ~i_in;
      CSRRWI:  w_next = w_zimm;
      CSRRSI:  w_next = r_data | w_zimm;
      CSRRCI:  w_next = r_data & ~w_zimm;
      default: w_next = r_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= ResetValue;
    end else if (i_en) begin
      r_data <= w_next;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR bank: address decode, slot array, 1-cycle write-back pipeline.
// Optional HIPPO_CSR_CYCLE_EN maps a 64-bit cycle counter read-only at 0xC00/0xC80.
module csr_file
  import decoder_pkg::*;
#(
  parameter int unsigned           NumCsr     = 4,
  parameter logic [CSR_ADDR_W-1:0] CsrBase    = 12'h300,
  parameter word                   ResetValue = '0
) (
  input logic        clk,
  input logic        reset,
  csr_file_if.slave  bus
);

  logic [CSR_ADDR_W-1:0] w_off;
  logic                  w_ro;
  logic                  w_ro_read;
  logic                  w_slot_hit;
  logic                  w_cyc_hit;
  logic                  w_mapped;
  logic                  w_illegal;
  logic                  w_legal;
  logic                  w_wb_en;
  logic [NumCsr-1:0]     w_slot_en;
  word                   w_slot_data [NumCsr];
  word                   w_pre;

  logic r_wb_en;
  r     r_wb_rd;
  word  r_wb_data;
  logic r_illegal;

  // Unsigned subtraction: addresses below CsrBase wrap high and miss.
  assign w_off      = bus.csr_addr - CsrBase;
  assign w_ro       = bus.csr_addr[11:10] == CSR_RO_PREFIX;
  assign w_ro_read  = (bus.op inside {CSRRS, CSRRC, CSRRSI, CSRRCI}) && (bus.rs1 == '0);
  assign w_slot_hit = !w_ro && (w_off < CSR_ADDR_W'(NumCsr));

`ifdef HIPPO_CSR_CYCLE_EN
  logic [63:0] r_cycle;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
    end
  end

  assign w_cyc_hit = (bus.csr_addr == CSR_CYCLE) || (bus.csr_addr == CSR_CYCLEH);
`else
  assign w_cyc_hit = 1'b0;
`endif

  assign w_mapped  = w_slot_hit || w_cyc_hit;
  assign w_illegal = bus.csr_enable && (!w_mapped || (w_ro && !w_ro_read));
  assign w_legal   = bus.csr_enable && w_mapped && !w_illegal;
  assign w_wb_en   = w_legal && (bus.rd != '0);

  always_comb begin
    w_slot_en = '0;
    w_pre     = '0;
    for (int unsigned i = 0; i < NumCsr; i++) begin
      if (w_off == CSR_ADDR_W'(i)) begin
        w_slot_en[i] = w_legal && w_slot_hit;
        w_pre        = w_slot_data[i];
      end
    end
`ifdef HIPPO_CSR_CYCLE_EN
    if (bus.csr_addr == CSR_CYCLE) begin
      w_pre = r_cycle[31:0];
    end else if (bus.csr_addr == CSR_CYCLEH) begin
      w_pre = r_cycle[63:32];
    end
`endif
  end

  for (genvar g = 0; g < NumCsr; g++) begin : g_slot
    csr #(
      .ResetValue (ResetValue)
    ) u_csr (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_slot_en[g]),
      .i_op   (bus.op),
      .i_rs1  (bus.rs1),
      .i_in   (bus.in),
      .o_data (w_slot_data[g])
    );
  end

  // Pre-op value is captured only for accesses that write back, so wb_data holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_wb_en   <= w_wb_en;
      r_wb_rd   <= bus.rd;
      r_illegal <= w_illegal;
      if (w_wb_en) begin
        r_wb_data <= w_pre;
      end
    end
  end

  assign bus.wb_en   = r_wb_en;
  assign bus.wb_rd   = r_wb_rd;
  assign bus.wb_data = r_wb_data;
  assign bus.illegal = r_illegal;

endmodule
